// File: rtl/note_div_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// note_div_scheduler_pkg
// Shared definitions for the note divider scheduler: default division
// constants, datapath widths, the scheduler state enum and the channel enum.
// -----------------------------------------------------------------------------
package note_div_scheduler_pkg;

    localparam int unsigned DIVIDEND  = 100_000_000; // numerator, fits in 27 bits
    localparam int unsigned SIL_CODE  = 100_000_000; // raw code meaning silence
    localparam int unsigned QW        = 22;          // output quotient width

    localparam int unsigned DVD_W     = 27;          // dividend / quotient width
    localparam int unsigned DVS_W     = 33;          // effective divisor width
    localparam int unsigned LAST_STEP = DVD_W - 1;   // index of final iteration

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DIV,
        DONE
    } state_t;

    typedef enum logic {
        L,
        R
    } chan_t;

endpackage

// File: rtl/note_div_scheduler_seq_div.sv
// -----------------------------------------------------------------------------
// seq_restoring_div
// Sequential restoring divider, one quotient bit per clock, MSB first.
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   start     : loads dividend/divisor, clears remainder and iteration count
//   dividend  : DVD_W-bit numerator
//   divisor   : DVS_W-bit denominator (must be non-zero for a valid result)
//   done      : high during the final iteration cycle; quotient is valid
//               from the following cycle until the next start
//   quotient  : DVD_W-bit quotient
// -----------------------------------------------------------------------------
module seq_restoring_div
    import note_div_scheduler_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             done,
    output logic [DVD_W-1:0] quotient
);

    logic [DVS_W-1:0] r_rem;
    logic [DVD_W-1:0] r_dq;    // shifts dividend bits out, quotient bits in
    logic [DVS_W-1:0] r_dvs;
    logic [4:0]       r_cnt;
    logic             r_run;

    logic [DVS_W:0]   w_shift;
    logic [DVS_W:0]   w_diff;
    logic             w_ge;

    assign w_shift = {r_rem, r_dq[DVD_W-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};
    // Remainder stays below the divisor, so the shifted value is below twice
    // the divisor: a non-negative difference always has its top bit clear and
    // a negative one always has it set.
    assign w_ge    = ~w_diff[DVS_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem <= '0;
            r_dq  <= '0;
            r_dvs <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (start) begin
            r_rem <= '0;
            r_dq  <= dividend;
            r_dvs <= divisor;
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (r_run) begin
            r_rem <= w_ge ? w_diff[DVS_W-1:0] : w_shift[DVS_W-1:0];
            r_dq  <= {r_dq[DVD_W-2:0], w_ge};
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'(LAST_STEP)) begin
                r_run <= 1'b0;
            end
        end
    end

    assign done     = r_run && (r_cnt == 5'(LAST_STEP));
    assign quotient = r_dq;

endmodule

// File: rtl/note_div_scheduler.sv
// -----------------------------------------------------------------------------
// note_div_scheduler
// Time-shares one sequential divider between the left and right channels to
// produce registered DIVIDEND / freq values for note_gen, applying octave
// shift, silence, zero-divisor and saturation rules. Channels alternate L, R.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   freqL, freqR    : raw 32-bit channel frequencies
//   octave          : 1 = down, 3 = up, anything else = normal
//   note_div_left   : registered left divider value (reset 1)
//   note_div_right  : registered right divider value (reset 1)
//   upd_left/right  : one-cycle pulse alongside a newly written value
//   busy            : high in LOAD, DIV and DONE
//
// Build option: NOTE_DIV_SKIP_EN -- skip a channel whose {silence, divisor}
// matches the last value it was computed for.
// -----------------------------------------------------------------------------
module note_div_scheduler #(
    parameter int unsigned DIVIDEND = note_div_scheduler_pkg::DIVIDEND,
    parameter int unsigned SIL_CODE = note_div_scheduler_pkg::SIL_CODE,
    parameter int unsigned QW       = note_div_scheduler_pkg::QW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   freqL,
    input  logic [31:0]   freqR,
    input  logic [2:0]    octave,
    output logic [QW-1:0] note_div_left,
    output logic [QW-1:0] note_div_right,
    output logic          upd_left,
    output logic          upd_right,
    output logic          busy
);

    import note_div_scheduler_pkg::*;

    state_t           r_state;
    state_t           w_nxt;
    chan_t            r_ch;
    logic             r_sil;
    logic             r_zero;
    logic [QW-1:0]    r_div_l;
    logic [QW-1:0]    r_div_r;
    logic             r_upd_l;
    logic             r_upd_r;

    logic [31:0]      w_f;
    logic [DVS_W-1:0] w_d;
    logic             w_sil;
    logic             w_zero;
    logic             w_start;
    logic             w_wr;
    logic             w_skip;
    logic             w_div_done;
    logic [DVD_W-1:0] w_q;
    logic             w_sat;
    logic [QW-1:0]    w_res;

    // Selected channel's effective divisor and bypass flags
    assign w_f = (r_ch == L) ? freqL : freqR;

    always_comb begin
        case (octave)
            3'd1:    w_d = {1'b0, w_f} >> 1;
            3'd3:    w_d = {w_f, 1'b0};
            default: w_d = {1'b0, w_f};
        endcase
    end

    assign w_sil  = (w_f == SIL_CODE);
    assign w_zero = (w_d == '0);

    seq_restoring_div u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (w_start),
        .dividend (DVD_W'(DIVIDEND)),
        .divisor  (w_d),
        .done     (w_div_done),
        .quotient (w_q)
    );

    assign w_sat = (w_q >> QW) != '0;

    always_comb begin
        if (r_sil) begin
            w_res = QW'(1);
        end else if (r_zero || w_sat) begin
            w_res = '1;
        end else begin
            w_res = w_q[QW-1:0];
        end
    end

`ifdef NOTE_DIV_SKIP_EN
    logic [DVS_W:0] r_key_l;
    logic [DVS_W:0] r_key_r;
    logic           r_vld_l;
    logic           r_vld_r;
    logic [DVS_W:0] w_key;

    assign w_key  = {w_sil, w_d};
    assign w_skip = (r_state == IDLE) &&
                    ((r_ch == L) ? (r_vld_l && (r_key_l == w_key))
                                 : (r_vld_r && (r_key_r == w_key)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_l <= '0;
            r_key_r <= '0;
            r_vld_l <= 1'b0;
            r_vld_r <= 1'b0;
        end else if (r_state == LOAD) begin
            if (r_ch == L) begin
                r_key_l <= w_key;
                r_vld_l <= 1'b1;
            end else begin
                r_key_r <= w_key;
                r_vld_r <= 1'b1;
            end
        end
    end
`else
    assign w_skip = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    // Next state and per-state strobes
    always_comb begin
        w_nxt   = r_state;
        w_start = 1'b0;
        w_wr    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_skip) begin
                    w_nxt = LOAD;
                end
            end
            LOAD: begin
                if (w_sil || w_zero) begin
                    w_nxt = DONE;
                end else begin
                    w_start = 1'b1;
                    w_nxt   = DIV;
                end
            end
            DIV: begin
                if (w_div_done) begin
                    w_nxt = DONE;
                end
            end
            DONE: begin
                w_wr  = 1'b1;
                w_nxt = IDLE;
            end
            default: w_nxt = IDLE;
        endcase
    end

    // Channel pointer, captured flags and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ch    <= L;
            r_sil   <= 1'b0;
            r_zero  <= 1'b0;
            r_div_l <= QW'(1);
            r_div_r <= QW'(1);
            r_upd_l <= 1'b0;
            r_upd_r <= 1'b0;
        end else begin
            if (r_state == LOAD) begin
                r_sil  <= w_sil;
                r_zero <= w_zero;
            end
            if (w_wr || w_skip) begin
                r_ch <= (r_ch == L) ? R : L;
            end
            r_upd_l <= w_wr && (r_ch == L);
            r_upd_r <= w_wr && (r_ch == R);
            if (w_wr && (r_ch == L)) begin
                r_div_l <= w_res;
            end
            if (w_wr && (r_ch == R)) begin
                r_div_r <= w_res;
            end
        end
    end

    assign note_div_left  = r_div_l;
    assign note_div_right = r_div_r;
    assign upd_left       = r_upd_l;
    assign upd_right      = r_upd_r;
    assign busy           = (r_state != IDLE);

endmodule

// File: tb/tb_note_div_scheduler.sv
// -----------------------------------------------------------------------------
// tb_note_div_scheduler
// Directed self-checking bench for note_div_scheduler with hand-computed
// quotients (100_000_000 / d) and cycle latencies counted from reset release.
// -----------------------------------------------------------------------------
module tb_note_div_scheduler;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic [31:0] freqL  = 32'd262;
    logic [31:0] freqR  = 32'd262;
    logic [2:0]  octave = 3'd2;
    logic [21:0] note_div_left;
    logic [21:0] note_div_right;
    logic        upd_left;
    logic        upd_right;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    note_div_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .freqL          (freqL),
        .freqR          (freqR),
        .octave         (octave),
        .note_div_left  (note_div_left),
        .note_div_right (note_div_right),
        .upd_left       (upd_left),
        .upd_right      (upd_right),
        .busy           (busy)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [31:0] fl, input logic [31:0] fr,
                               input logic [2:0] oc);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        freqL  = fl;
        freqR  = fr;
        octave = oc;
        tick(5);
        rst = 1'b0;
    endtask

    // Edges until the chosen upd pulse is seen; -1 when the bound expires.
    task automatic wait_upd(input bit right, input int max, output int n);
        int i;
        bit hit;
        n   = -1;
        i   = 0;
        hit = 1'b0;
        while (!hit && i < max) begin
            @(posedge clk);
            #1;
            i++;
            if ((right ? upd_right : upd_left) === 1'b1) begin
                hit = 1'b1;
                n   = i;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1; freqL = 262; freqR = 262; octave = 2;
        tick(5);
        checks++; if (note_div_left !== 22'd1) begin errors++; $display("FAIL reset_left: got %0d, expected 1", note_div_left); end
        checks++; if (note_div_right !== 22'd1) begin errors++; $display("FAIL reset_right: got %0d, expected 1", note_div_right); end
        checks++; if (upd_left !== 1'b0) begin errors++; $display("FAIL reset_upd_left: got %b, expected 0", upd_left); end
        checks++; if (upd_right !== 1'b0) begin errors++; $display("FAIL reset_upd_right: got %b, expected 0", upd_right); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        rst = 1'b0;
        tick(1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_load: got %b, expected 1", busy); end
        wait_upd(1'b0, 100, n);
        checks++; if (n !== 29) begin errors++; $display("FAIL first_left_latency: got %0d, expected 29 (edge 30)", n); end
        checks++; if (note_div_left !== 22'd381679) begin errors++; $display("FAIL first_left_value: got %0d, expected 381679", note_div_left); end
        wait_upd(1'b1, 100, n);
        checks++; if (n !== 30) begin errors++; $display("FAIL first_right_latency: got %0d, expected 30", n); end
        checks++; if (note_div_right !== 22'd381679) begin errors++; $display("FAIL first_right_value: got %0d, expected 381679", note_div_right); end
        tick(1);
        checks++; if (upd_right !== 1'b0) begin errors++; $display("FAIL upd_right_width: got %b, expected 0", upd_right); end
    endtask

    task automatic test_octave();
        logic [2:0]  oc  [3] = '{3'd1, 3'd3, 3'd0};
        logic [21:0] exp [3] = '{22'd763358, 22'd190839, 22'd381679};
        int n;
        for (int i = 0; i < 3; i++) begin
            apply_reset(32'd262, 32'd262, oc[i]);
            wait_upd(1'b0, 100, n);
            checks++; if (n !== 30) begin errors++; $display("FAIL octave%0d_latency: got %0d, expected 30", oc[i], n); end
            checks++; if (note_div_left !== exp[i]) begin errors++; $display("FAIL octave%0d_value: got %0d, expected %0d", oc[i], note_div_left, exp[i]); end
        end
    endtask

    task automatic test_silence();
        int n;
        for (int oc = 1; oc <= 3; oc++) begin
            apply_reset(32'd262, 32'd100_000_000, 3'(oc));
            wait_upd(1'b0, 100, n);
            wait_upd(1'b1, 100, n);
            checks++; if (n !== 3) begin errors++; $display("FAIL silence_oct%0d_latency: got %0d, expected 3", oc, n); end
            checks++; if (note_div_right !== 22'd1) begin errors++; $display("FAIL silence_oct%0d_value: got %0d, expected 1", oc, note_div_right); end
        end
    endtask

    task automatic test_zero_sat();
        logic [31:0] fl  [3] = '{32'd0, 32'd10, 32'd24};
        logic [21:0] exp [3] = '{22'd4194303, 22'd4194303, 22'd4166666};
        int          lat [3] = '{3, 30, 30};
        int n;
        for (int i = 0; i < 3; i++) begin
            apply_reset(fl[i], 32'd262, 3'd2);
            wait_upd(1'b0, 100, n);
            checks++; if (n !== lat[i]) begin errors++; $display("FAIL freq%0d_latency: got %0d, expected %0d", fl[i], n, lat[i]); end
            checks++; if (note_div_left !== exp[i]) begin errors++; $display("FAIL freq%0d_value: got %0d, expected %0d", fl[i], note_div_left, exp[i]); end
        end
    endtask

    task automatic test_midchange();
        int n;
        apply_reset(32'd262, 32'd262, 3'd2);
        tick(15);
        freqL = 32'd440;
        wait_upd(1'b0, 100, n);
        checks++; if (n !== 15) begin errors++; $display("FAIL midchange_latency: got %0d, expected 15", n); end
        checks++; if (note_div_left !== 22'd381679) begin errors++; $display("FAIL midchange_current: got %0d, expected 381679", note_div_left); end
        wait_upd(1'b0, 100, n);
        checks++; if (n !== 60) begin errors++; $display("FAIL midchange_next_latency: got %0d, expected 60", n); end
        checks++; if (note_div_left !== 22'd227272) begin errors++; $display("FAIL midchange_next_value: got %0d, expected 227272", note_div_left); end
    endtask

    // Continues from test_midchange: left holds 227272, right holds 381679.
    task automatic test_reset_mid();
        int pulses;
        freqR = 32'd300;
        tick(10);
        rst = 1'b1;
        #1;
        checks++; if (note_div_left !== 22'd1) begin errors++; $display("FAIL midreset_left: got %0d, expected 1", note_div_left); end
        checks++; if (note_div_right !== 22'd1) begin errors++; $display("FAIL midreset_right: got %0d, expected 1", note_div_right); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b, expected 0", busy); end
        pulses = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (upd_left !== 1'b0 || upd_right !== 1'b0) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midreset_pulses: got %0d, expected 0", pulses); end
        rst = 1'b0;
    endtask

`ifdef NOTE_DIV_SKIP_EN
    task automatic test_skip();
        int cl;
        int cr;
        apply_reset(32'd262, 32'd262, 3'd2);
        cl = 0; cr = 0;
        repeat (1000) begin
            @(posedge clk);
            #1;
            if (upd_left === 1'b1) cl++;
            if (upd_right === 1'b1) cr++;
        end
        checks++; if (cl !== 1) begin errors++; $display("FAIL skip_left_count: got %0d, expected 1", cl); end
        checks++; if (cr !== 1) begin errors++; $display("FAIL skip_right_count: got %0d, expected 1", cr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL skip_idle_busy: got %b, expected 0", busy); end
        freqR = 32'd440;
        cl = 0; cr = 0;
        repeat (200) begin
            @(posedge clk);
            #1;
            if (upd_left === 1'b1) cl++;
            if (upd_right === 1'b1) cr++;
        end
        checks++; if (cl !== 0) begin errors++; $display("FAIL skip_change_left: got %0d, expected 0", cl); end
        checks++; if (cr !== 1) begin errors++; $display("FAIL skip_change_right: got %0d, expected 1", cr); end
        checks++; if (note_div_right !== 22'd227272) begin errors++; $display("FAIL skip_change_value: got %0d, expected 227272", note_div_right); end
    endtask
`else
    task automatic test_back_to_back();
        int n;
        apply_reset(32'd262, 32'd262, 3'd2);
        wait_upd(1'b0, 100, n);
        checks++; if (n !== 30) begin errors++; $display("FAIL alternation_first: got %0d, expected 30", n); end
        wait_upd(1'b0, 100, n);
        checks++; if (n !== 60) begin errors++; $display("FAIL alternation_period: got %0d, expected 60", n); end
        wait_upd(1'b0, 100, n);
        checks++; if (n !== 60) begin errors++; $display("FAIL alternation_period2: got %0d, expected 60", n); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_octave();
        test_silence();
        test_zero_sat();
        test_midchange();
        test_reset_mid();
`ifdef NOTE_DIV_SKIP_EN
        test_skip();
`else
        test_back_to_back();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/note_div_scheduler.md
# note_div_scheduler

Sequential replacement for the two combinational `100_000_000 / freq` dividers that sit between the music source and `note_gen`. It time-shares one 27-iteration restoring divider between the left and right channels. It applies the octave shift and the silence/zero/overflow rules, and holds registered `note_div_left` / `note_div_right` values that feed `note_gen` directly.

## Interface
Parameters:
- `DIVIDEND`, default 100_000_000: numerator of every division; must fit in 27 bits.
- `SIL_CODE`, default 100_000_000: raw frequency code that means silence.
- `QW`, default 22: output quotient width.

Ports (clock and reset first):
- `clk` — input, 1 bit: system clock. One clock domain.
- `rst` — input, 1 bit: asynchronous, active-high reset.
- `freqL` — input, 32 bits: raw left-channel frequency from the music module.
- `freqR` — input, 32 bits: raw right-channel frequency.
- `octave` — input, 3 bits: 1 = down, 2 = normal, 3 = up. Any other value is treated as 2.
- `note_div_left` — output, QW bits: registered left divider value.
- `note_div_right` — output, QW bits: registered right divider value.
- `upd_left` — output, 1 bit: one-cycle pulse when `note_div_left` is written.
- `upd_right` — output, 1 bit: one-cycle pulse when `note_div_right` is written.
- `busy` — output, 1 bit: high while in LOAD, DIV or DONE.

## Operation
Effective divisor `d` is 33 bits wide, computed from the selected channel's frequency `f`:
- octave 1 → `d = f >> 1`.
- octave 3 → `d = {f, 1'b0}`; no truncation.
- otherwise → `d = f`.

Result rules, in priority order:
- `f == SIL_CODE` → result 1.
- `d == 0` → result `{QW{1'b1}}`.
- otherwise → `DIVIDEND / d`, truncated toward zero, saturated to `{QW{1'b1}}` when ≥ 2^QW. With the defaults this happens for d ≤ 23.

State machine:
- IDLE (1 cycle): `ch` selects the channel; move to LOAD.
- LOAD (1 cycle): capture the selected `f`, `d` and the bypass flags.
  - Silence or zero → DONE.
  - Otherwise clear the remainder, load the dividend, clear the iteration counter, and go to DIV.
- DIV (27 cycles): one restoring step per cycle, MSB first. After iteration 26, go to DONE.
- DONE (1 cycle): write the result to the selected channel's output, pulse its `upd_*`, toggle `ch`, and return to IDLE.

Sequencing and boundary rules:
- Channel order is strict alternation: L, R, L, R, … After reset, `ch` = L.
- Inputs that change during LOAD/DIV/DONE do not abort the operation. The new value is taken at that channel's next LOAD.
- `octave` is sampled only in LOAD, so one round can use different octaves for L and R.
- Outputs hold their value between writes. There is no write enable from outside.
- Reset at any time: return to IDLE, clear all datapath registers, apply the output reset values below.

## Timing
Reset values:
- `note_div_left` = `note_div_right` = 1 (silence).
- `upd_left` = `upd_right` = 0.
- `busy` = 0.
- `ch` = L.

Latency and throughput:
- Divide path: IDLE→DONE takes 30 cycles. The output updates on the clock edge that ends DONE.
- Bypass path (silence or zero): 3 cycles.
- Full L+R refresh: ≤ 60 cycles, i.e. 0.6 µs at 100 MHz.

Signal behaviour:
- `upd_*` is registered and high for exactly the cycle after the write edge, together with the new value.
- `busy` is low only in IDLE.

## Configuration
- `NOTE_DIV_SKIP_EN` defined:
  - Per channel, store the last captured `{f == SIL_CODE, d}` and a valid bit (cleared by reset).
  - In IDLE, if the current value matches the stored one and valid is set, toggle `ch` and stay in IDLE. No LOAD, no `upd_*`.
  - With constant inputs, exactly one L update and one R update occur after reset, then the block stays idle.
- `NOTE_DIV_SKIP_EN` not defined: continuous L/R alternation. No compare registers are built.

## Structure
- Shared package holds `DIVIDEND`, `SIL_CODE`, `QW`, the state enum (IDLE, LOAD, DIV, DONE), and the channel enum (L, R).
- One sub-module, `seq_restoring_div`:
  - Dividend 27 bits, divisor 33 bits.
  - Handshake: `start` in, `done` out, quotient out.
  - One bit per cycle.
  - The scheduler owns the bypass, saturation and channel logic.

## Test plan
- Reset, then hold `rst` for 5 cycles: both outputs 1, `upd_*` 0, `busy` 0. Release with `freqL` = 262, `freqR` = 262, octave 2: `upd_left` on cycle 30 with value 381679, then `upd_right` 30 cycles later with value 381679.
- Octave sweep with `freqL` = 262: octave 1 → 763358, octave 3 → 190839, octave 0 → 381679.
- `freqR` = 100_000_000 at octaves 1, 2 and 3: `note_div_right` = 1 every time, with `upd_right` 3 cycles after entering IDLE for R.
- `freqL` = 0 → 4194303. `freqL` = 10 → 4194303 (saturated). `freqL` = 24 → 4166666.
- Change `freqL` from 262 to 440 in the middle of a DIV on L: the current write is 381679, and the next L write is 227272. Assert `rst` mid-DIV: outputs return to 1 immediately and no `upd_*` pulse occurs.
- With `NOTE_DIV_SKIP_EN`: hold inputs constant for 1000 cycles and expect exactly one `upd_left` and one `upd_right`. Change `freqR` and expect exactly one more `upd_right`. Without the macro: `upd_left` every 60 cycles.
